spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_shift_engine.sv | 185 ++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master byte shift engine; optional chip-select hold under SPI_CS_HOLD_EN
`timescale 1ns/1ps

module spi_shift_engine #(
    parameter int CLOCK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [CLOCK_WIDTH-1:0] clockScale,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic                   msbFirst,
    input  logic                   start,
    input  logic [7:0]             dataIn,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             dataOut,
    output logic                   spi_en,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    output logic                   spi_cs
`ifdef SPI_CS_HOLD_EN
    ,
    input  logic                   csHold
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, FINISH} state_t;

    state_t state, state_next;

    logic [CLOCK_WIDTH-1:0] div_cnt;
    logic [CLOCK_WIDTH-1:0] lat_scale;
    logic [3:0]             half_cnt;
    logic                   lat_cpol;
    logic                   lat_cpha;
    logic                   lat_msb;
    logic [7:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic                   mosi_r;
    logic                   sck_r;
    logic                   run_ok;
    logic                   cs_held;

    logic                   accept;
    logic                   half_end;
    logic                   last_half;
    logic                   sck_edge;
    logic [3:0]             edge_idx;
    logic                   edge_lead;
    logic                   shift_tx;
    logic                   sample_rx;

    function automatic logic first_bit(input logic [7:0] b, input logic msb);
        return msb ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] drop_bit(input logic [7:0] b, input logic msb);
        return msb ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    // Edge k of 16 happens at the start of half-period k; even k is a leading edge.
    always_comb begin
        half_end  = (div_cnt == lat_scale);
        last_half = (half_cnt == 4'd15);
        accept    = (state == IDLE) && start && enable;
        sck_edge  = 1'b0;
        edge_idx  = 4'd0;
        if (state == SETUP && half_end) begin
            sck_edge = 1'b1;
            edge_idx = 4'd0;
        end else if (state == SHIFT && half_end && !last_half) begin
            sck_edge = 1'b1;
            edge_idx = half_cnt + 4'd1;
        end
        edge_lead = ~edge_idx[0];
        sample_rx = sck_edge && (lat_cpha ? !edge_lead : edge_lead);
        shift_tx  = sck_edge && (lat_cpha ? edge_lead : (!edge_lead && edge_idx != 4'd15));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   if (half_end) state_next = SHIFT;
            SHIFT:   if (half_end && last_half) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            lat_scale <= '0;
            half_cnt  <= 4'd0;
            lat_cpol  <= 1'b0;
            lat_cpha  <= 1'b0;
            lat_msb   <= 1'b0;
            tx_shift  <= 8'h00;
            rx_shift  <= 8'h00;
            mosi_r    <= 1'b0;
            sck_r     <= 1'b0;
            run_ok    <= 1'b0;
            dataOut   <= 8'h00;
        end else begin
            run_ok <= 1'b1;
            if (accept) begin
                lat_scale <= clockScale;
                lat_cpol  <= cpol;
                lat_cpha  <= cpha;
                lat_msb   <= msbFirst;
                div_cnt   <= '0;
                half_cnt  <= 4'd0;
                sck_r     <= cpol;
                rx_shift  <= 8'h00;
                // With cpha=0 the first bit must already be on the line during SETUP.
                if (cpha) begin
                    tx_shift <= dataIn;
                    mosi_r   <= 1'b0;
                end else begin
                    tx_shift <= drop_bit(dataIn, msbFirst);
                    mosi_r   <= first_bit(dataIn, msbFirst);
                end
            end else if (state == SETUP || state == SHIFT) begin
                div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                if (state == SHIFT && half_end) begin
                    half_cnt <= half_cnt + 4'd1;
                end
                if (sck_edge) begin
                    sck_r <= ~sck_r;
                end
                if (shift_tx) begin
                    mosi_r   <= first_bit(tx_shift, lat_msb);
                    tx_shift <= drop_bit(tx_shift, lat_msb);
                end
                if (sample_rx) begin
                    rx_shift <= lat_msb ? {rx_shift[6:0], spi_miso} : {spi_miso, rx_shift[7:1]};
                end
                if (state == SHIFT && state_next == FINISH) begin
                    dataOut <= rx_shift;
                end
            end else begin
                div_cnt  <= '0;
                half_cnt <= 4'd0;
            end
        end
    end

`ifdef SPI_CS_HOLD_EN
    // Chip select stays asserted after a transfer while csHold is requested at FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_held <= 1'b0;
        end else if (state == FINISH) begin
            cs_held <= csHold && enable;
        end else if (!csHold || !enable) begin
            cs_held <= 1'b0;
        end
    end
`else
    assign cs_held = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    assign spi_en   = enable;
    assign spi_cs   = (state == IDLE) ? ~cs_held : 1'b0;
    assign spi_mosi = (state == IDLE) ? 1'b0 : mosi_r;
    assign spi_clk  = (state == IDLE) ? (cpol & run_ok) : sck_r;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine; cs-hold case under SPI_CS_HOLD_EN
`timescale 1ns/1ps

module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] clockScale = 8'd0;
    logic       cpol = 1'b1;
    logic       cpha = 1'b0;
    logic       msbFirst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] dataOut;
    logic       spi_en;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs;
`ifdef SPI_CS_HOLD_EN
    logic       csHold = 1'b0;
`endif

    spi_shift_engine #(.CLOCK_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clockScale (clockScale),
        .cpol       (cpol),
        .cpha       (cpha),
        .msbFirst   (msbFirst),
        .start      (start),
        .dataIn     (dataIn),
        .busy       (busy),
        .done       (done),
        .dataOut    (dataOut),
        .spi_en     (spi_en),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_cs     (spi_cs)
`ifdef SPI_CS_HOLD_EN
        ,
        .csHold     (csHold)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] mosi;
        int         cycles;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    logic [7:0] slv_byte = 8'h00;
    logic       slv_cpha = 1'b0;
    logic       slv_msb = 1'b1;
    logic       slv_tie = 1'b0;
    int         sck_edges = 0;
    int         busy_cnt = 0;
    int         rises = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    int         slv_k;
    logic [2:0] slv_bit;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Slave: cpha=0 presents bit k after 2k SCK edges, cpha=1 after the (2k+1)th edge.
    always_comb begin
        slv_k = slv_cpha ? (sck_edges - 1) / 2 : sck_edges / 2;
        if (slv_k < 0) slv_k = 0;
        if (slv_k > 7) slv_k = 7;
        slv_bit  = slv_k[2:0];
        spi_miso = slv_tie ? 1'b1 : slv_byte[slv_msb ? 3'd7 - slv_bit : slv_bit];
    end

    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
            if (spi_clk != prev_sck) begin
                sck_edges++;
                if (spi_clk) rises++;
                if (slv_cpha ? (sck_edges % 2 == 0) : (sck_edges % 2 == 1))
                    mosi_cap = slv_msb ? {mosi_cap[6:0], spi_mosi} : {spi_mosi, mosi_cap[7:1]};
            end
        end else begin
            busy_cnt  = 0;
            sck_edges = 0;
            rises     = 0;
        end
        prev_sck = spi_clk;
        if (done) begin
            check("done_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("dataOut", int'(dataOut), int'(e.dout));
                check("mosi_byte", int'(mosi_cap), int'(e.mosi));
                check("busy_cycles", busy_cnt, e.cycles);
                check("sck_rises", rises, 8);
            end
        end
    end

    task automatic expect_xfer(input logic [7:0] dout, input logic [7:0] mosi, input int cycles);
        exp_t e;
        e.dout   = dout;
        e.mosi   = mosi;
        e.cycles = cycles;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [7:0] din, input logic [7:0] scale, input logic pol,
                         input logic pha, input logic msb, input logic [7:0] sbyte, input logic tie);
        @(negedge clk);
        dataIn     = din;
        clockScale = scale;
        cpol       = pol;
        cpha       = pha;
        msbFirst   = msb;
        slv_byte   = sbyte;
        slv_cpha   = pha;
        slv_msb    = msb;
        slv_tie    = tie;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(done), 1);
    endtask

    initial begin
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dataOut", int'(dataOut), 0);
        check("rst_cs", int'(spi_cs), 1);
        check("rst_mosi", int'(spi_mosi), 0);
        check("rst_sck", int'(spi_clk), 0);
        check("rst_spi_en", int'(spi_en), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("sck_follows_cpol", int'(spi_clk), 1);
        enable = 1'b1;
        @(negedge clk);
        check("spi_en", int'(spi_en), 1);

        expect_xfer(8'h3C, 8'hA5, 35);
        issue(8'hA5, 8'd1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        wait_done("xfer_a5_done");
        @(negedge clk);
        check("idle_cs_after_a5", int'(spi_cs), 1);
        check("idle_mosi_after_a5", int'(spi_mosi), 0);

        issue(8'h77, 8'd3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_cs", int'(spi_cs), 1);
        check("abort_done", int'(done), 0);
        check("abort_dataOut", int'(dataOut), 8'h3C);
        check("abort_spi_en", int'(spi_en), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;

        expect_xfer(8'hFF, 8'h01, 18);
        issue(8'h01, 8'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        wait_done("xfer_01_done");
        @(negedge clk);
        check("idle_sck_high", int'(spi_clk), 1);
        check("idle_cs_after_01", int'(spi_cs), 1);

        expect_xfer(8'hC3, 8'h5A, 35);
        issue(8'h5A, 8'd1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0);
        repeat (5) @(negedge clk);
        start      = 1'b1;
        clockScale = 8'd0;
        msbFirst   = 1'b1;
        cpha       = 1'b0;
        cpol       = 1'b1;
        dataIn     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done("xfer_5a_done");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_finish_ignored", int'(busy), 0);
        @(negedge clk);
        check("still_idle", int'(busy), 0);

        issue(8'h99, 8'd1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        repeat (8) @(negedge clk);
        cpol = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_dataOut", int'(dataOut), 0);
        check("midrst_cs", int'(spi_cs), 1);
        check("midrst_mosi", int'(spi_mosi), 0);
        check("midrst_sck", int'(spi_clk), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("sck_after_rst", int'(spi_clk), 1);

`ifdef SPI_CS_HOLD_EN
        csHold = 1'b1;
        expect_xfer(8'hA1, 8'h12, 18);
        issue(8'h12, 8'd0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        wait_done("hold_12_done");
        @(negedge clk);
        check("hold_cs_between", int'(spi_cs), 0);
        expect_xfer(8'h5E, 8'h34, 18);
        issue(8'h34, 8'd0, 1'b0, 1'b0, 1'b1, 8'h5E, 1'b0);
        check("hold_cs_second", int'(spi_cs), 0);
        wait_done("hold_34_done");
        @(negedge clk);
        check("hold_cs_after", int'(spi_cs), 0);
        csHold = 1'b0;
        @(negedge clk);
        check("hold_cs_release", int'(spi_cs), 1);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
